// File: rtl/tmds_pkg.sv
// Shared TMDS symbol tables (control tokens, guard bands, TERC4) and period type,
// used by the encoder here and by the HDMI receive decoder.
package tmds_pkg;

  typedef enum logic [1:0] {
    PERIOD_CONTROL,
    PERIOD_VIDEO,
    PERIOD_ISLAND,
    PERIOD_GUARD
  } period_e;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;

  function automatic logic [9:0] ctrl_token(input logic [1:0] ctrl);
    case (ctrl)
      2'b00:   return CTRL_TOKEN_00;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Video guard band: lanes 0 and 2 share one code, lane 1 uses its complement.
  function automatic logic [9:0] guard_band(input int channel);
    return (channel == 1) ? 10'b0100110011 : 10'b1011001100;
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

endpackage

// File: rtl/tmds_qm.sv
// Transition-minimising first stage of TMDS: picks XOR/XNOR chaining from the
// byte's popcount and also reports the popcount of the resulting q_m[7:0].
module tmds_qm
  import tmds_pkg::*;
(
  input  logic [7:0] data,
  output logic [8:0] q_m,
  output logic [3:0] q_m_ones
);

  logic [3:0] data_ones;
  logic       use_xnor;

  always_comb begin
    data_ones = '0;
    for (int i = 0; i < 8; i++) data_ones = data_ones + {3'b000, data[i]};

    use_xnor = (data_ones > 4'd4) || ((data_ones == 4'd4) && !data[0]);

    q_m    = '0;
    q_m[0] = data[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
    q_m[8] = ~use_xnor;

    q_m_ones = '0;
    for (int i = 0; i < 8; i++) q_m_ones = q_m_ones + {3'b000, q_m[i]};
  end

endmodule

// File: rtl/tmds_encoder.sv
// Two-stage DVI/HDMI TMDS lane encoder with running-disparity control.
// Define TMDS_TERC4_EN to add HDMI data-island (TERC4) and guard-band symbols.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
`ifdef TMDS_TERC4_EN
  input  logic       island,
  input  logic       guard,
  input  logic [3:0] aux,
`endif
  output logic [9:0] tmds
);

  if (CHANNEL < 0 || CHANNEL > 2) begin : g_bad_channel
    $error("tmds_encoder: CHANNEL must be 0, 1 or 2");
  end

  period_e          period_in, period_s1;
  logic [1:0]       ctrl_s1;
  logic [8:0]       qm_in, qm_s1;
  logic [3:0]       ones_in, ones_s1;
  logic signed [4:0] cnt, cnt_next, diff;
  logic [9:0]       tmds_next;
`ifdef TMDS_TERC4_EN
  logic [3:0]       aux_s1;
`endif

  tmds_qm u_qm (
    .data     (data),
    .q_m      (qm_in),
    .q_m_ones (ones_in)
  );

  always_comb begin
    period_in = de ? PERIOD_VIDEO : PERIOD_CONTROL;
`ifdef TMDS_TERC4_EN
    if (guard)       period_in = PERIOD_GUARD;
    else if (island) period_in = PERIOD_ISLAND;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_s1 <= PERIOD_CONTROL;
      ctrl_s1   <= '0;
      qm_s1     <= '0;
      ones_s1   <= '0;
`ifdef TMDS_TERC4_EN
      aux_s1    <= '0;
`endif
    end else begin
      period_s1 <= period_in;
      ctrl_s1   <= ctrl;
      qm_s1     <= qm_in;
      ones_s1   <= ones_in;
`ifdef TMDS_TERC4_EN
      aux_s1    <= aux;
`endif
    end
  end

  // diff = ones - zeros = 2*ones - 8, computed mod 32; the result always fits -8..+8.
  assign diff = $signed({ones_s1, 1'b0}) - 5'sd8;

  always_comb begin
    tmds_next = ctrl_token(ctrl_s1);
    cnt_next  = '0;
    case (period_s1)
      PERIOD_VIDEO: begin
        if (cnt == 0 || diff == 0) begin
          tmds_next = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
          cnt_next  = cnt + (qm_s1[8] ? diff : -diff);
        end else if ((cnt > 0 && diff > 0) || (cnt < 0 && diff < 0)) begin
          tmds_next = {1'b1, qm_s1[8], ~qm_s1[7:0]};
          cnt_next  = cnt + (qm_s1[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
          tmds_next = {1'b0, qm_s1[8], qm_s1[7:0]};
          cnt_next  = cnt + diff - (qm_s1[8] ? 5'sd0 : 5'sd2);
        end
      end
`ifdef TMDS_TERC4_EN
      PERIOD_ISLAND: tmds_next = terc4(aux_s1);
      PERIOD_GUARD:  tmds_next = guard_band(CHANNEL);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmds <= CTRL_TOKEN_00;
      cnt  <= '0;
    end else begin
      tmds <= tmds_next;
      cnt  <= cnt_next;
    end
  end

endmodule
